// File: rtl/lc3_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lc3_seq_ctrl
// Brief    : LC-3 instruction sequencer (fetch, decode, control-flow, exec handoff)
// Revision : 1.0
// ============================================================================
module lc3_seq_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic        mem_ready,
    input  logic        exec_done,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        ldIR,
    output logic        ldPC,
    output logic        ldR7,
    output logic [1:0]  selPC,
    output logic        gatePC,
    output logic        gateMDR,
    output logic        addr1_sel,
    output logic [1:0]  addr2_sel,
    output logic        mem_en,
    output logic        exec_start,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH1    = 4'd1,
        S_FETCH2    = 4'd2,
        S_FETCH3    = 4'd3,
        S_DECODE    = 4'd4,
        S_BR_TAKE   = 4'd5,
        S_JMP       = 4'd6,
        S_JSR       = 4'd7,
        S_EXEC      = 4'd8,
        S_EXEC_WAIT = 4'd9,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [7:0] C_WAIT_LAST = (MEM_TIMEOUT == 0) ? 8'd0 : 8'(MEM_TIMEOUT - 1);
    localparam bit         C_TO_EN     = (MEM_TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        w_complete;
    logic        w_unused;

    assign w_unused    = &{1'b0, ir[8:0]};
    assign state       = state_q;
    assign instr_count = instr_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 8'd0;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        instr_count_d = instr_count_q;
        w_complete    = 1'b0;
        ldMAR         = 1'b0;
        ldMDR         = 1'b0;
        ldIR          = 1'b0;
        ldPC          = 1'b0;
        ldR7          = 1'b0;
        selPC         = 2'b00;
        gatePC        = 1'b0;
        gateMDR       = 1'b0;
        addr1_sel     = 1'b0;
        addr2_sel     = 2'b00;
        mem_en        = 1'b0;
        exec_start    = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;

        case (state_q)
            S_IDLE: begin
                halted = 1'b1;
                if (run) state_d = S_FETCH1;
            end
            S_FETCH1: begin
                gatePC     = 1'b1;
                ldMAR      = 1'b1;
                ldPC       = 1'b1;
                wait_cnt_d = 8'd0;
                state_d    = S_FETCH2;
            end
            S_FETCH2: begin
                mem_en = 1'b1;
                ldMDR  = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH3;
                end else if (C_TO_EN && (wait_cnt_q == C_WAIT_LAST)) begin
                    state_d = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_FETCH3: begin
                gateMDR = 1'b1;
                ldIR    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (ir[15:12])
                    4'b0000: begin
                        if ((ir[11] & n) | (ir[10] & z) | (ir[9] & p)) state_d = S_BR_TAKE;
                        else w_complete = 1'b1;
                    end
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR;
                    4'b1101: state_d = S_FAULT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_BR_TAKE: begin
                addr2_sel  = 2'b01;
                ldPC       = 1'b1;
                selPC      = 2'b01;
                w_complete = 1'b1;
            end
            S_JMP: begin
                addr1_sel  = 1'b1;
                ldPC       = 1'b1;
                selPC      = 2'b01;
                w_complete = 1'b1;
            end
            S_JSR: begin
                // R7 and PC share this edge: R7 captures the old PC, JSRR R7 jumps via old R7
                gatePC     = 1'b1;
                ldR7       = 1'b1;
                ldPC       = 1'b1;
                selPC      = 2'b01;
                addr1_sel  = ~ir[11];
                addr2_sel  = ir[11] ? 2'b10 : 2'b00;
                w_complete = 1'b1;
            end
            S_EXEC: begin
                exec_start = 1'b1;
                state_d    = S_EXEC_WAIT;
            end
            S_EXEC_WAIT: begin
                if (exec_done) w_complete = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (w_complete) begin
            instr_count_d = instr_count_q + 16'd1;
            state_d       = run ? S_FETCH1 : S_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lc3_seq_ctrl
// Brief    : Directed + randomized bench for lc3_seq_ctrl with instruction-level model
// Revision : 1.0
// ============================================================================
module tb_lc3_seq_ctrl;

    localparam int TO = 15;

    typedef struct packed {
        logic [3:0] s;
        logic       m;
        logic       e;
    } step_t;

    logic        clk = 1'b0;
    logic        reset, run, n, z, p, mem_ready, exec_done;
    logic [15:0] ir;
    logic        ldMAR, ldMDR, ldIR, ldPC, ldR7, gatePC, gateMDR, addr1_sel;
    logic        mem_en, exec_start, halted, fault;
    logic [1:0]  selPC, addr2_sel;
    logic [3:0]  state;
    logic [15:0] instr_count;
    logic [15:0] ctrl_obs;

    int vectors     = 0;
    int miscompares = 0;
    int model_cnt   = 0;

    always #5 clk = ~clk;

    lc3_seq_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .ir(ir), .n(n), .z(z), .p(p),
        .mem_ready(mem_ready), .exec_done(exec_done),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .ldIR(ldIR), .ldPC(ldPC), .ldR7(ldR7),
        .selPC(selPC), .gatePC(gatePC), .gateMDR(gateMDR),
        .addr1_sel(addr1_sel), .addr2_sel(addr2_sel), .mem_en(mem_en),
        .exec_start(exec_start), .halted(halted), .fault(fault),
        .state(state), .instr_count(instr_count)
    );

    assign ctrl_obs = {ldMAR, ldMDR, ldIR, ldPC, ldR7, selPC, gatePC, gateMDR,
                       addr1_sel, addr2_sel, mem_en, exec_start, halted, fault};

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic step_t mk(input int s, input bit m, input bit e);
        step_t t;
        t.s = 4'(s);
        t.m = m;
        t.e = e;
        return t;
    endfunction

    // Control word expected for a state, straight from the per-state output table
    function automatic logic [15:0] exp_ctrl(input int s, input logic [15:0] i_ir, input logic mr);
        logic lmar = 0, lmdr = 0, lir = 0, lpc = 0, lr7 = 0, gpc = 0, gmdr = 0;
        logic a1 = 0, men = 0, exs = 0, hlt = 0, flt = 0;
        logic [1:0] spc = 2'b00, a2 = 2'b00;
        case (s)
            0:  hlt = 1;
            1:  begin gpc = 1; lmar = 1; lpc = 1; end
            2:  begin men = 1; lmdr = mr; end
            3:  begin gmdr = 1; lir = 1; end
            5:  begin a2 = 2'b01; lpc = 1; spc = 2'b01; end
            6:  begin a1 = 1; lpc = 1; spc = 2'b01; end
            7:  begin
                    gpc = 1; lr7 = 1; lpc = 1; spc = 2'b01;
                    if (i_ir[11]) a2 = 2'b10;
                    else a1 = 1;
                end
            8:  exs = 1;
            15: flt = 1;
            default: ;
        endcase
        return {lmar, lmdr, lir, lpc, lr7, spc, gpc, gmdr, a1, a2, men, exs, hlt, flt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enter_fetch();
        run = 1'b1;
        @(negedge clk);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(0, ir, mem_ready)));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(0, ir, mem_ready)));
        chk("rst_count", 32'(instr_count), 32'd0);
        model_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        chk("rst_hold", 32'(state), 32'd0);
        @(posedge clk); #1;
        enter_fetch();
    endtask

    task automatic hold_fault();
        for (int c = 0; c < 3; c++) begin
            run = rb(); mem_ready = rb(); exec_done = rb();
            @(negedge clk);
            chk("fault_state", 32'(state), 32'd15);
            chk("fault_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(15, ir, mem_ready)));
            @(posedge clk); #1;
        end
    endtask

    // Called with the DUT in FETCH1. w = FETCH2 wait cycles before mem_ready,
    // k = EXEC_WAIT cycles (done on the k-th), early = exec_done during EXEC.
    task automatic do_instr(input logic [15:0] i_ir, input logic [2:0] nzp, input int w,
                            input int k, input bit early, input bit run_after);
        step_t q[$];
        bit done = 1'b1;
        logic [3:0] op = i_ir[15:12];
        logic [2:0] cond = i_ir[11:9];
        q.push_back(mk(1, rb(), rb()));
        if (w >= TO) begin
            for (int j = 0; j < TO; j++) q.push_back(mk(2, 0, rb()));
            q.push_back(mk(15, rb(), rb()));
            done = 1'b0;
        end else begin
            for (int j = 0; j < w; j++) q.push_back(mk(2, 0, rb()));
            q.push_back(mk(2, 1, rb()));
            q.push_back(mk(3, rb(), rb()));
            q.push_back(mk(4, rb(), rb()));
            if (op == 4'h0) begin
                if ((cond & nzp) != 3'b000) q.push_back(mk(5, rb(), rb()));
            end else if (op == 4'hC) begin
                q.push_back(mk(6, rb(), rb()));
            end else if (op == 4'h4) begin
                q.push_back(mk(7, rb(), rb()));
            end else if (op == 4'hD) begin
                q.push_back(mk(15, rb(), rb()));
                done = 1'b0;
            end else begin
                q.push_back(mk(8, rb(), early));
                for (int j = 0; j < k - 1; j++) q.push_back(mk(9, rb(), 0));
                q.push_back(mk(9, rb(), 1));
            end
        end
        for (int idx = 0; idx < q.size(); idx++) begin
            ir = i_ir;
            {n, z, p} = nzp;
            mem_ready = q[idx].m;
            exec_done = q[idx].e;
            run = (done && idx == q.size() - 1) ? run_after : rb();
            @(negedge clk);
            chk("state", 32'(state), 32'(q[idx].s));
            chk("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(int'(q[idx].s), ir, mem_ready)));
            chk("count", 32'(instr_count), 32'(model_cnt));
            @(posedge clk); #1;
        end
        if (done) begin
            model_cnt = (model_cnt + 1) % 65536;
            if (!run_after) enter_fetch();
            chk("after_count", 32'(instr_count), 32'(model_cnt));
        end
    endtask

    initial begin
        logic [15:0] rir;
        reset = 1'b0; run = 1'b0; ir = 16'h0; n = 0; z = 0; p = 0;
        mem_ready = 1'b0; exec_done = 1'b0;
        #12;
        chk("init_state", 32'(state), 32'd0);
        chk("init_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(0, ir, mem_ready)));
        chk("init_count", 32'(instr_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_run0", 32'(state), 32'd0);
        @(posedge clk); #1;
        chk("idle_stay", 32'(state), 32'd0);
        enter_fetch();

        do_instr(16'h0A05, 3'b010, 0, 1, 0, 1);   // BRnp, z: not taken
        do_instr(16'h0A05, 3'b100, 0, 1, 0, 1);   // BRnp, n: taken
        do_instr(16'h4803, 3'b001, 0, 1, 0, 1);   // JSR
        do_instr(16'h41C0, 3'b001, 0, 1, 0, 1);   // JSRR R7
        do_instr(16'h1021, 3'b001, 0, 3, 1, 1);   // ADD, early exec_done ignored
        do_instr(16'hC1C0, 3'b010, 2, 1, 0, 1);   // RET with mem waits
        do_instr(16'h1021, 3'b100, TO - 1, 1, 0, 1); // ready on last allowed cycle
        do_instr(16'h5020, 3'b010, 0, 2, 0, 0);   // run dropped -> IDLE

        for (int t = 0; t < 300; t++) begin
            rir = 16'($urandom);
            if (rir[15:12] == 4'hD) rir[15:12] = 4'h1;
            do_instr(rir, 3'($urandom), $urandom_range(0, 3), $urandom_range(1, 4),
                     rb(), ($urandom_range(0, 3) != 0));
        end

        // asynchronous reset while waiting in FETCH2
        run = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        chk("f2_before_rst", 32'(state), 32'd2);
        #2;
        do_reset();

        do_instr(16'h1021, 3'b000, TO, 1, 0, 1);  // memory timeout
        hold_fault();
        do_reset();

        do_instr(16'hD000, 3'b000, 0, 1, 0, 1);   // reserved opcode
        hold_fault();
        do_reset();

        do_instr(16'h0E00, 3'b001, 0, 1, 0, 1);
        chk("final_count", 32'(instr_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
